// File: rtl/mine_board_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : mine_board_gen_if
// Brief   : Control and read-port bundle between the board generator and its user.
// Revision: 1.0 - initial release
// ============================================================================
interface mine_board_gen_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int NCELLS = ROWS * COLS;
  localparam int IW     = $clog2(NCELLS);
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);

  logic          start;
  logic [15:0]   seed;
  logic [IW:0]   num_mines;
  logic          busy;
  logic          done;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [3:0]    rd_cell;

  modport master (
    output start, seed, num_mines, rd_row, rd_col,
    input  busy, done, rd_cell
  );

  modport slave (
    input  start, seed, num_mines, rd_row, rd_col,
    output busy, done, rd_cell
  );
endinterface
`default_nettype wire

// File: rtl/mine_board_gen.sv
`default_nettype none
// ============================================================================
// Module  : mine_board_gen
// Brief   : Clears a board, places LFSR-chosen mines, fills neighbour counts.
// Revision: 1.0 - initial release
// ============================================================================
module mine_board_gen #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mine_board_gen_if.slave   bus
);
  localparam int NCELLS = ROWS * COLS;
  localparam int IW     = $clog2(NCELLS);
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);

  localparam logic [15:0] c_lfsr_default = 16'hACE1;
  localparam logic [15:0] c_lfsr_mask    = 16'hB400;
  localparam logic [3:0]  c_mine         = 4'd9;
  localparam logic [IW:0] c_ncells       = (IW+1)'(NCELLS);
  localparam logic [IW-1:0] c_last_idx   = IW'(NCELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PLACE = 3'd2,
    S_COUNT = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cells [NCELLS];
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_n;
  logic [IW-1:0] r_placed;
  logic [15:0]   r_lfsr;
  logic [3:0]    r_rd_cell;

  logic          w_start_ok;
  logic          w_idx_last;
  logic [IW-1:0] w_cand;
  logic          w_place;
  logic [15:0]   w_lfsr_step;
  logic [IW-1:0] w_n_clamp;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic [3:0]    w_nbr_cnt;
  logic          w_busy_nxt;
  logic [IW-1:0] w_rd_idx;

  assign w_start_ok  = bus.start && (r_state == S_IDLE || r_state == S_FIN);
  assign w_idx_last  = (r_idx == c_last_idx);
  assign w_cand      = r_lfsr[IW-1:0];
  assign w_place     = (r_placed != r_n) && (r_cells[w_cand] != c_mine);
  assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_mask : 16'h0000);
  assign w_n_clamp   = (bus.num_mines >= c_ncells) ? c_last_idx : bus.num_mines[IW-1:0];
  assign w_row       = r_idx[IW-1:CW];
  assign w_col       = r_idx[CW-1:0];
  assign w_busy_nxt  = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_PLACE) ||
                       (w_state_nxt == S_COUNT);
  // Power-of-two columns make row*COLS+col a plain concatenation.
  assign w_rd_idx    = {bus.rd_row, bus.rd_col};

  assign bus.busy    = (r_state == S_CLEAR) || (r_state == S_PLACE) || (r_state == S_COUNT);
  assign bus.done    = (r_state == S_FIN);
  assign bus.rd_cell = r_rd_cell;

  always_comb begin
    w_nbr_cnt = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) &&
            (int'(w_row) + dr >= 0) && (int'(w_row) + dr < ROWS) &&
            (int'(w_col) + dc >= 0) && (int'(w_col) + dc < COLS)) begin
          if (r_cells[IW'((int'(w_row) + dr) * COLS + int'(w_col) + dc)] == c_mine) begin
            w_nbr_cnt = w_nbr_cnt + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_idx_last) w_state_nxt = S_PLACE;
      S_PLACE: if (r_placed == r_n) w_state_nxt = S_COUNT;
      S_COUNT: if (w_idx_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = w_start_ok ? S_CLEAR : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_n       <= '0;
      r_placed  <= '0;
      r_lfsr    <= c_lfsr_default;
      r_rd_cell <= 4'd0;
      for (int i = 0; i < NCELLS; i++) begin
        r_cells[i] <= 4'd0;
      end
    end else begin
      r_rd_cell <= w_busy_nxt ? 4'd0 : r_cells[w_rd_idx];
      case (r_state)
        S_IDLE, S_FIN: begin
          if (w_start_ok) begin
            r_n      <= w_n_clamp;
            r_lfsr   <= (bus.seed == 16'h0000) ? c_lfsr_default : bus.seed;
            r_idx    <= '0;
            r_placed <= '0;
          end
        end
        S_CLEAR: begin
          r_cells[r_idx] <= 4'd0;
          r_idx          <= r_idx + IW'(1);
        end
        S_PLACE: begin
          r_lfsr <= w_lfsr_step;
          if (w_place) begin
            r_cells[w_cand] <= c_mine;
            r_placed        <= r_placed + IW'(1);
          end
        end
        S_COUNT: begin
          // Counts never reach 9, so already-written cells still read as safe.
          if (r_cells[r_idx] != c_mine) begin
            r_cells[r_idx] <= w_nbr_cnt;
          end
          r_idx <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mine_board_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_mine_board_gen
// Brief   : Self-checking bench for mine_board_gen against a board-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mine_board_gen;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int NCELLS = ROWS * COLS;
  localparam int MAXCYC = 20000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mine_board_gen_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  mine_board_gen #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_board [NCELLS];
  int         m_steps;

  typedef struct {
    logic [15:0] seed;
    int          nm;
    int          exp_mines;
    int          ignore_at;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Board produced by the rules: random placement until n mines, then neighbour counts.
  task automatic model(input logic [15:0] sd, input int nm);
    int n;
    int placed;
    int cand;
    int cnt;
    logic [15:0] l;
    n = (nm > NCELLS - 1) ? NCELLS - 1 : nm;
    for (int i = 0; i < NCELLS; i++) m_board[i] = 4'd0;
    l       = (sd == 16'h0000) ? 16'hACE1 : sd;
    placed  = 0;
    m_steps = 0;
    while (placed < n) begin
      cand = int'(l) % NCELLS;
      if (m_board[cand] != 4'd9) begin
        m_board[cand] = 4'd9;
        placed++;
      end
      l = (l >> 1) ^ ((l & 16'h0001) != 16'h0000 ? 16'hB400 : 16'h0000);
      m_steps++;
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (m_board[r*COLS+c] != 4'd9) begin
          cnt = 0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < ROWS &&
                  c+dc >= 0 && c+dc < COLS && m_board[(r+dr)*COLS+c+dc] == 4'd9) cnt++;
            end
          end
          m_board[r*COLS+c] = 4'(cnt);
        end
      end
    end
  endtask

  task automatic read_board(input string name, input bit all_zero, output int mines);
    int exp;
    mines = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.rd_row = 3'(r);
        bus.rd_col = 3'(c);
        @(posedge clk); #1;
        exp = all_zero ? 0 : int'(m_board[r*COLS+c]);
        check($sformatf("%s cell(%0d,%0d)", name, r, c), int'(bus.rd_cell), exp);
        if (bus.rd_cell == 4'd9) mines++;
      end
    end
  endtask

  // Called at #1 after an edge; leaves the bench at #1 after the accepting edge.
  task automatic start_pulse(input logic [15:0] sd, input int nm);
    bus.start     = 1'b1;
    bus.seed      = sd;
    bus.num_mines = 7'(nm);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int ignore_at, output int lat);
    lat = 1;
    while (!bus.done && lat < MAXCYC) begin
      if (lat == ignore_at) begin
        bus.start     = 1'b1;
        bus.seed      = 16'h9999;
        bus.num_mines = 7'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    check({name, " done seen"}, int'(bus.done), 1);
    check({name, " busy low in done cycle"}, int'(bus.busy), 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    int mines;
    model(v.seed, v.nm);
    @(posedge clk); #1;
    start_pulse(v.seed, v.nm);
    check({name, " busy after start"}, int'(bus.busy), 1);
    check({name, " rd_cell zero while busy"}, int'(bus.rd_cell), 0);
    wait_done(name, v.ignore_at, lat);
    check({name, " latency"}, lat, 2*NCELLS + 2 + m_steps);
    if (v.nm == 0) check({name, " empty-board latency"}, lat, 130);
    @(posedge clk); #1;
    check({name, " done single pulse"}, int'(bus.done), 0);
    check({name, " idle busy"}, int'(bus.busy), 0);
    read_board(name, 1'b0, mines);
    check({name, " mine count"}, mines, v.exp_mines);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   mines;
    vec_t rv;

    bus.start     = 1'b0;
    bus.seed      = 16'h0000;
    bus.num_mines = '0;
    bus.rd_row    = '0;
    bus.rd_col    = '0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset rd_cell", int'(bus.rd_cell), 0);
    reset = 1'b0;
    read_board("after reset", 1'b1, mines);
    check("after reset mines", mines, 0);

    vecs[0] = '{seed: 16'h1234, nm: 0,   exp_mines: 0,  ignore_at: 0};
    vecs[1] = '{seed: 16'h1234, nm: 10,  exp_mines: 10, ignore_at: 0};
    vecs[2] = '{seed: 16'h5A5A, nm: 64,  exp_mines: 63, ignore_at: 0};
    vecs[3] = '{seed: 16'h0000, nm: 12,  exp_mines: 12, ignore_at: 0};
    vecs[4] = '{seed: 16'hACE1, nm: 12,  exp_mines: 12, ignore_at: 0};
    vecs[5] = '{seed: 16'h1234, nm: 10,  exp_mines: 10, ignore_at: 20};
    vecs[6] = '{seed: 16'hBEEF, nm: 127, exp_mines: 63, ignore_at: 0};
    vecs[7] = '{seed: 16'h0001, nm: 1,   exp_mines: 1,  ignore_at: 0};

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Start during the done cycle begins the next run straight away.
    model(16'h2222, 5);
    @(posedge clk); #1;
    start_pulse(16'h2222, 5);
    wait_done("b2b first", 0, lat);
    check("b2b first latency", lat, 2*NCELLS + 2 + m_steps);
    model(16'h3333, 4);
    start_pulse(16'h3333, 4);
    check("b2b second busy", int'(bus.busy), 1);
    wait_done("b2b second", 0, lat);
    check("b2b second latency", lat, 2*NCELLS + 2 + m_steps);
    @(posedge clk); #1;
    read_board("b2b second", 1'b0, mines);
    check("b2b second mines", mines, 4);

    // Reset in the middle of mine placement wipes everything.
    @(posedge clk); #1;
    start_pulse(16'h7777, 63);
    repeat (69) @(posedge clk);
    #1;
    check("abort busy before reset", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort rd_cell", int'(bus.rd_cell), 0);
    #2;
    reset = 1'b0;
    read_board("after abort", 1'b1, mines);
    check("after abort mines", mines, 0);
    rv = '{seed: 16'h4321, nm: 9, exp_mines: 9, ignore_at: 0};
    run_vec(rv, "post-abort");

    for (int k = 0; k < 3; k++) begin
      rv.seed      = 16'($urandom);
      rv.nm        = int'($urandom_range(0, 40));
      rv.exp_mines = rv.nm;
      rv.ignore_at = 0;
      run_vec(rv, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
